serial_add_seq: RTL and testbench
=================================

Name: serial_add_seq

Overview:
- Bit-serial adder controller. Accepts two W-bit operands and a carry-in over a valid/ready handshake.
- Sequences a single one-bit full-add cell (two HalfAdder instances plus an OR for carry) across W cycles, LSB first. Presents the W-bit sum and carry-out over a second valid/ready handshake.
- Sits between the operand source and the result consumer wherever area matters more than latency.

Parameters:
- W, 8, operand/sum width in bits; legal range 1..64.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  operand source has A, B, CIN valid.
- IN_READY  output  1  block can accept operands; high only in IDLE.
- A  input  W  operand A, sampled on acceptance.
- B  input  W  operand B, sampled on acceptance.
- CIN  input  1  carry-in, sampled on acceptance.
- OUT_VALID  output  1  S/COUT hold a completed result; high only in DONE.
- OUT_READY  input  1  consumer accepts the result.
- S  output  W  sum, registered.
- COUT  output  1  final carry-out, registered.
- BUSY  output  1  high in RUN or DONE.

Behaviour:
- One clock (CLK); reset is asynchronous and active-high (RST).
- State register: IDLE, RUN, DONE.
- Internal registers: shift registers SA, SB (W bits each), sum shift register SR (W bits), carry flop CY, bit counter CNT (width clog2(W)+1).
- Reset (asserted at any time, including mid-RUN): state=IDLE; SA, SB, SR, CY, CNT all cleared; S=0; COUT=0; OUT_VALID=0; BUSY=0; IN_READY=1 after reset. An in-flight operation is dropped with no output.
- IN_READY, OUT_VALID and BUSY are decoded from the registered state; there are no combinational paths from inputs to outputs.
- IDLE: IN_READY=1. On an edge with IN_VALID=1: SA<=A, SB<=B, CY<=CIN, CNT<=0, SR<=0, go to RUN. Otherwise stay in IDLE.
- RUN: each edge, the cell computes s=SA[0]^SB[0]^CY and c=(SA[0]&SB[0])|((SA[0]^SB[0])&CY).
  - SR<={s, SR[W-1:1]}; SA, SB shift right by one (zero fill); CY<=c; CNT<=CNT+1.
  - On the edge where CNT==W-1: go to DONE; S<={s, SR[W-1:1]}; COUT<=c.
- DONE: OUT_VALID=1. S and COUT are held stable while OUT_READY=0 (no timeout). On an edge with OUT_READY=1: go to IDLE. S and COUT keep their value until the next completion or reset.
- Latency: operands accepted at edge t0; OUT_VALID is high from edge t0+W. Minimum initiation interval is W+2 cycles (one DONE cycle with immediate OUT_READY, one IDLE cycle). Acceptance and completion never occur in the same cycle.
- IN_VALID in RUN or DONE is ignored (IN_READY=0); operand inputs may change freely after acceptance.
- OUT_READY outside DONE is ignored.
- Wrap-around: the sum is modulo 2^W; overflow is reported only through COUT (unsigned carry).
- W=1: RUN lasts exactly one cycle; behaviour is otherwise identical.

Test Plan:
- Reset, then idle with IN_VALID=0 -> IN_READY=1, OUT_VALID=0, BUSY=0, S=0x00, COUT=0.
- W=8: A=0x35, B=0x4A, CIN=0, OUT_READY=1, accept at t0 -> OUT_VALID rises at t0+8 with S=0x7F, COUT=0; IDLE at t0+9; IN_READY high at t0+9.
- W=8: A=0xFF, B=0x01, CIN=0 -> S=0x00, COUT=1. Also A=0xFF, B=0xFF, CIN=1 -> S=0xFF, COUT=1.
- Backpressure: OUT_READY=0 for 5 cycles after OUT_VALID -> S/COUT stable, OUT_VALID held. Toggle IN_VALID, A, B during RUN and DONE -> no effect on the result.
- Assert RST at the 4th RUN cycle of A=0x12, B=0x34 -> outputs return to reset values immediately. No OUT_VALID is ever produced for that operation. The next operation A=0x01, B=0x02 gives S=0x03.
- Back-to-back: three operations with IN_VALID and OUT_READY held high -> acceptances spaced exactly W+2 cycles apart. Results checked against a reference model (A+B+CIN), plus 1000 random vectors for W=1, 8 and 13.

Source files
------------

// File: rtl/serial_add_seq_if.sv
// ---------------------------------------------------------------------------
// serial_add_seq_if
// Handshake bundle for the bit-serial adder.
//   in_valid / in_ready : operand handshake (source -> adder)
//   a, b, cin           : operands, sampled when the adder accepts them
//   out_valid/out_ready : result handshake (adder -> consumer)
//   s, cout             : registered sum and carry-out
//   busy                : adder is running or holding a result
// The master modport is the operand source / result consumer side and the
// slave modport is the adder side.
// ---------------------------------------------------------------------------
interface serial_add_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, s, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, s, cout, busy
    );
endinterface

// File: rtl/serial_add_seq.sv
// ---------------------------------------------------------------------------
// serial_add_seq
// Bit-serial adder controller. Operands are accepted in IDLE, added one bit
// per cycle (LSB first) through a single full-add cell built from two
// HalfAdder instances, and the W-bit sum plus carry-out is held in DONE until
// the consumer takes it.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset; drops any in-flight operation
//   bus  : serial_add_seq_if slave modport (operand and result handshakes)
// Latency: operands accepted on edge t0, out_valid high from edge t0+W.
// ---------------------------------------------------------------------------

// One-bit half adder used twice to form the full-add cell.
module HalfAdder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_add_seq #(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_seq_if.slave   bus
);
    // One extra counter bit keeps the width legal for W=1.
    localparam int            CW       = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q;
    logic [W-1:0]  sa_q;
    logic [W-1:0]  sb_q;
    logic [W-1:0]  sr_q;
    logic [W-1:0]  s_q;
    logic          cy_q;
    logic          cout_q;
    logic [CW-1:0] cnt_q;

    logic [W-1:0]  sa_d;
    logic [W-1:0]  sb_d;
    logic [W-1:0]  sr_d;
    logic          ha0_s;
    logic          ha0_c;
    logic          ha1_s;
    logic          ha1_c;
    logic          bit_s;
    logic          bit_c;

    // Full-add cell: first half adder combines the operand bits, the second
    // folds in the running carry; either half producing a carry propagates it.
    HalfAdder u_ha0 (
        .a_i (sa_q[0]),
        .b_i (sb_q[0]),
        .s_o (ha0_s),
        .c_o (ha0_c)
    );

    HalfAdder u_ha1 (
        .a_i (ha0_s),
        .b_i (cy_q),
        .s_o (ha1_s),
        .c_o (ha1_c)
    );

    assign bit_s = ha1_s;
    assign bit_c = ha0_c | ha1_c;

    // Next values of the shift registers during RUN. The new sum bit enters
    // at the MSB so that after W shifts bit 0 of the sum sits at SR[0]; the
    // OR/shift form avoids an empty slice when W=1.
    always_comb begin
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        sr_d = (sr_q >> 1) | (W'(bit_s) << (W - 1));
    end

    // Controller: IDLE waits for operands, RUN steps one bit per edge and
    // latches the final sum/carry on the last bit, DONE holds the result
    // until the consumer is ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            s_q     <= '0;
            cy_q    <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sa_q    <= bus.a;
                        sb_q    <= bus.b;
                        cy_q    <= bus.cin;
                        cnt_q   <= '0;
                        sr_q    <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sa_q  <= sa_d;
                    sb_q  <= sb_d;
                    sr_q  <= sr_d;
                    cy_q  <= bit_c;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_q <= DONE;
                        s_q     <= sr_d;
                        cout_q  <= bit_c;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode only the state register, so no input reaches
    // an output combinationally.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// ---------------------------------------------------------------------------
// tb_serial_add_seq
// Drives three adders (W=1, 8, 13) in lockstep from one set of stimulus
// variables and compares them against plain-arithmetic sums A+B+CIN.
// ---------------------------------------------------------------------------
module tb_serial_add_seq;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] expS;
        logic       expCout;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        outReady;
    logic        cin;
    logic [63:0] opA;
    logic [63:0] opB;

    int checks = 0;
    int errors = 0;

    vec_t        vecs[7];
    logic [7:0]  b2bA[3];
    logic [7:0]  b2bB[3];
    logic        b2bC[3];
    logic [8:0]  results[$];
    int          accCyc[3];

    serial_add_seq_if #(.W(1))  bus1 ();
    serial_add_seq_if #(.W(8))  bus8 ();
    serial_add_seq_if #(.W(13)) bus13 ();

    assign bus1.in_valid   = inValid;
    assign bus1.a          = opA[0:0];
    assign bus1.b          = opB[0:0];
    assign bus1.cin        = cin;
    assign bus1.out_ready  = outReady;
    assign bus8.in_valid   = inValid;
    assign bus8.a          = opA[7:0];
    assign bus8.b          = opB[7:0];
    assign bus8.cin        = cin;
    assign bus8.out_ready  = outReady;
    assign bus13.in_valid  = inValid;
    assign bus13.a         = opA[12:0];
    assign bus13.b         = opB[12:0];
    assign bus13.cin       = cin;
    assign bus13.out_ready = outReady;

    serial_add_seq #(.W(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
    serial_add_seq #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    serial_add_seq #(.W(13)) dut13 (.clk(clk), .rst(rst), .bus(bus13));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Reference: unsigned sum of the low w bits of each operand plus carry-in.
    function automatic logic [64:0] refSum(input logic [63:0] a, input logic [63:0] b, input logic c, input int w);
        logic [64:0] mask;
        mask = (65'd1 << w) - 65'd1;
        return ({1'b0, a} & mask) + ({1'b0, b} & mask) + {64'd0, c};
    endfunction

    function automatic logic [63:0] refS(input logic [64:0] sum, input int w);
        logic [64:0] mask;
        mask = (65'd1 << w) - 65'd1;
        return sum[63:0] & mask[63:0];
    endfunction

    // One full transaction on all three adders with immediate OUT_READY;
    // returns the W=8 result for table comparison.
    task automatic applyStimulus(input logic [63:0] va, input logic [63:0] vb, input logic vc,
                                 output logic [63:0] s8, output logic c8);
        int          seen[3];
        logic [63:0] capS[3];
        logic        capC[3];
        logic        rdyAfter;
        int          widths[3];
        logic [64:0] sum;
        widths   = '{1, 8, 13};
        seen     = '{-1, -1, -1};
        capS     = '{64'd0, 64'd0, 64'd0};
        capC     = '{1'b0, 1'b0, 1'b0};
        rdyAfter = 1'b0;
        @(negedge clk);
        opA      = va;
        opB      = vb;
        cin      = vc;
        inValid  = 1'b1;
        outReady = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        opA     = {$urandom, $urandom};
        opB     = {$urandom, $urandom};
        cin     = 1'($urandom);
        checkOutput("busyAfterAccept", 64'(bus8.busy), 64'd1);
        checkOutput("readyAfterAccept", 64'(bus8.in_ready), 64'd0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (bus1.out_valid && seen[0] < 0) begin
                seen[0] = k; capS[0] = 64'(bus1.s); capC[0] = bus1.cout;
            end
            if (bus8.out_valid && seen[1] < 0) begin
                seen[1] = k; capS[1] = 64'(bus8.s); capC[1] = bus8.cout;
            end
            if (bus13.out_valid && seen[2] < 0) begin
                seen[2] = k; capS[2] = 64'(bus13.s); capC[2] = bus13.cout;
            end
            if (k == 9) rdyAfter = bus8.in_ready;
        end
        for (int i = 0; i < 3; i++) begin
            sum = refSum(va, vb, vc, widths[i]);
            checkOutput($sformatf("latencyW%0d", widths[i]), 64'(seen[i]), 64'(widths[i]));
            checkOutput($sformatf("sumW%0d", widths[i]), capS[i], refS(sum, widths[i]));
            checkOutput($sformatf("coutW%0d", widths[i]), 64'(capC[i]), 64'(sum[widths[i]]));
        end
        checkOutput("readyAfterDoneW8", 64'(rdyAfter), 64'd1);
        s8 = capS[1];
        c8 = capC[1];
    endtask

    initial begin
        logic [63:0] s8;
        logic        c8;
        logic        sawValid;
        logic [64:0] sum;
        bit          pending;
        int          nAcc;

        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        b2bA = '{8'h35, 8'hFF, 8'h80};
        b2bB = '{8'h4A, 8'h01, 8'h7F};
        b2bC = '{1'b0, 1'b0, 1'b1};

        rst      = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        cin      = 1'b0;
        opA      = '0;
        opB      = '0;

        // Reset and idle state.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("resetInReady", 64'(bus8.in_ready), 64'd1);
        checkOutput("resetOutValid", 64'(bus8.out_valid), 64'd0);
        checkOutput("resetBusy", 64'(bus8.busy), 64'd0);
        checkOutput("resetS", 64'(bus8.s), 64'd0);
        checkOutput("resetCout", 64'(bus8.cout), 64'd0);
        checkOutput("resetInReadyW13", 64'(bus13.in_ready), 64'd1);

        // Table-driven directed vectors.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(64'(vecs[i].a), 64'(vecs[i].b), vecs[i].cin, s8, c8);
            checkOutput($sformatf("tableS%0d", i), s8, 64'(vecs[i].expS));
            checkOutput($sformatf("tableCout%0d", i), 64'(c8), 64'(vecs[i].expCout));
        end

        // Backpressure with inputs toggling during RUN and DONE.
        @(negedge clk);
        opA      = 64'h11;
        opB      = 64'h22;
        cin      = 1'b0;
        inValid  = 1'b1;
        outReady = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            inValid = 1'($urandom_range(0, 1));
            opA     = {$urandom, $urandom};
            opB     = {$urandom, $urandom};
            cin     = 1'($urandom);
        end
        inValid = 1'b0;
        for (int h = 0; h < 5; h++) begin
            checkOutput("holdValidW8", 64'(bus8.out_valid), 64'd1);
            checkOutput("holdSW8", 64'(bus8.s), 64'h33);
            checkOutput("holdCoutW8", 64'(bus8.cout), 64'd0);
            checkOutput("holdSW13", 64'(bus13.s), 64'h33);
            checkOutput("holdSW1", 64'(bus1.s), 64'd1);
            @(negedge clk);
        end
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("releaseReadyW8", 64'(bus8.in_ready), 64'd1);
        checkOutput("releaseReadyW13", 64'(bus13.in_ready), 64'd1);
        checkOutput("releaseReadyW1", 64'(bus1.in_ready), 64'd1);

        // Reset during the fourth RUN cycle drops the operation.
        @(negedge clk);
        opA     = 64'h12;
        opB     = 64'h34;
        cin     = 1'b0;
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midResetInReady", 64'(bus8.in_ready), 64'd1);
        checkOutput("midResetBusy", 64'(bus8.busy), 64'd0);
        checkOutput("midResetOutValid", 64'(bus8.out_valid), 64'd0);
        checkOutput("midResetS", 64'(bus8.s), 64'd0);
        checkOutput("midResetCout", 64'(bus8.cout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sawValid = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            sawValid = sawValid | bus8.out_valid;
        end
        checkOutput("noValidAfterReset", 64'(sawValid), 64'd0);
        applyStimulus(64'h01, 64'h02, 1'b0, s8, c8);
        checkOutput("postResetS", s8, 64'h03);

        // Back-to-back operations with IN_VALID and OUT_READY held high.
        @(negedge clk);
        opA      = 64'(b2bA[0]);
        opB      = 64'(b2bB[0]);
        cin      = b2bC[0];
        inValid  = 1'b1;
        outReady = 1'b1;
        nAcc     = 0;
        pending  = 1'b0;
        results.delete();
        for (int t = 0; t < 60 && results.size() < 3; t++) begin
            if (bus8.out_valid) results.push_back({bus8.cout, bus8.s});
            if (pending) begin
                if (nAcc < 3) begin
                    opA = 64'(b2bA[nAcc]);
                    opB = 64'(b2bB[nAcc]);
                    cin = b2bC[nAcc];
                end else begin
                    inValid = 1'b0;
                end
                pending = 1'b0;
            end
            if (bus8.in_ready && inValid && nAcc < 3) begin
                accCyc[nAcc] = t;
                nAcc++;
                pending = 1'b1;
            end
            @(negedge clk);
        end
        inValid = 1'b0;
        checkOutput("b2bResultCount", 64'(results.size()), 64'd3);
        checkOutput("b2bAcceptCount", 64'(nAcc), 64'd3);
        if (nAcc == 3) begin
            checkOutput("b2bSpacing01", 64'(accCyc[1] - accCyc[0]), 64'd10);
            checkOutput("b2bSpacing12", 64'(accCyc[2] - accCyc[1]), 64'd10);
        end
        for (int i = 0; i < 3; i++) begin
            if (results.size() > i) begin
                sum = refSum(64'(b2bA[i]), 64'(b2bB[i]), b2bC[i], 8);
                checkOutput($sformatf("b2bResult%0d", i), 64'(results[i]), {55'd0, sum[8:0]});
            end
        end
        repeat (16) @(negedge clk);

        // Random vectors on all three widths.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), s8, c8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
